fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, fully pipelined floating-point multiplier that replaces the fixed 24-bit combinational float datapath feeding the codec interface. It accepts one operand pair per cycle over a valid/ready handshake and rounds to nearest-even. Each operand pair carries a tag so that several codec channels can share one unit. Results emerge in order, three cycles later, with full backpressure support.

## Interface
- `EXP_W`, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 15: stored mantissa width (hidden 1 implied); word = 1+EXP_W+MAN_W (default 24).
- `TAG_W`, default 2: channel tag width, passed through unchanged.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: operand pair present.
- `in_ready`, out, 1: unit accepts the pair this cycle.
- `in_a`, `in_b`, in, 1+EXP_W+MAN_W: operands {sign, exp, man}.
- `in_tag`, in, TAG_W: channel id.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, 1+EXP_W+MAN_W: product.
- `out_tag`, out, TAG_W: tag of that product.
- `out_flags`, out, 4: {invalid, overflow, underflow, inexact}; present only with `FP_MUL_FLAGS_EN`.

## Operation
- Classification: exp=0 is zero (subnormals flushed to zero, sign kept). exp=all-ones with man=0 is infinity. exp=all-ones with man≠0 is NaN.
- Sign = sign_a XOR sign_b for every non-NaN result.
- Special cases, in priority order:
  - Any NaN, or inf×0, gives canonical NaN: sign 0, exp all-ones, man MSB only (0x7FC000 at defaults); sets invalid.
  - Otherwise inf×x gives signed infinity.
  - Otherwise 0×x gives signed zero.
- Normal path, stage 1:
  - Exponent sum e = ea+eb-bias, computed in EXP_W+2 bits signed.
  - Mantissa product (MAN_W+1)×(MAN_W+1) gives 2·MAN_W+2 bits.
- Normal path, stage 2:
  - If the product MSB is set, shift right 1 and add 1 to e.
  - Keep MAN_W fraction bits, a guard bit and a sticky bit (OR of the rest).
  - Round to nearest-even: increment if guard & (sticky | lsb).
  - A rounding carry-out renormalises (mantissa 0, e+1).
  - inexact = guard | sticky.
- Normal path, stage 3:
  - e ≥ 2^EXP_W-1: signed infinity; sets overflow and inexact.
  - e ≤ 0: signed zero; sets underflow and inexact.
  - Otherwise pack {sign, e[EXP_W-1:0], man}.

## Timing
- Latency is exactly 3 cycles from accepted input (in_valid & in_ready) to out_valid when out_ready stays high. Throughput is 1 result per cycle.
- Stage valids v1..v3. advance = !v3 | out_ready. All stages shift together on advance.
- in_ready = advance, combinational from out_ready and v3. No input is dropped while in_ready is 0.
- out_valid = v3. out_data, out_tag and out_flags are registered and held stable while out_valid & !out_ready.
- Bubbles propagate. With in_valid low, the stage valid clears on advance. Bubbles are not compacted when advance=0.
- Reset (async assert, any time including mid-stream):
  - v1..v3, out_valid, out_data, out_tag and out_flags go to 0.
  - In-flight operations are discarded.
  - in_ready = 1 in the first cycle after deassert.
- Simultaneous accept and output in one cycle is legal and sustains full rate.

## Configuration
- `FP_MUL_FLAGS_EN` defined:
  - out_flags port exists.
  - Flags travel with their result through the pipeline and are valid when out_valid=1.
  - Flags reset to 0.
- Undefined: the port and all flag registers are absent. Datapath results are identical.

## Structure
- Package `fp_pkg`:
  - class encoding (ZERO, NORM, INF, NAN)
  - flag bit-index localparams
  - a function returning canonical NaN for given EXP_W/MAN_W
  - the bias computation
- Sub-module `fp_mul_round`: combinational normalise/guard/sticky/round-nearest-even logic, instantiated between the stage 1 and stage 2 registers. The top holds the handshake, stage registers and special-case muxing.

## Test plan
All values at defaults (EXP_W=8, MAN_W=15), out_ready=1 unless stated.
- 0x3FC000 × 0x3FC000 (1.5×1.5) → 0x401000 (2.25) exactly 3 cycles later; flags 0.
- Tie case 0x3FC000 × 0x3F8001 → 0x3FC002 (rounded up to even); inexact=1.
- Overflow 0x7F7FFF × 0x400000 → 0x7F8000 with overflow, inexact. Next, 0x7F8000 × 0x000000 → 0x7FC000 with invalid.
- Underflow 0x008000 × 0x3F0000 → 0x000000 with underflow. Next, 0x808000 × 0x3F0000 → 0x800000.
- Backpressure: stream 5 pairs with tags 0..3,0 and hold out_ready low 6 cycles.
  - in_ready falls after 3 accepts.
  - out_data/out_tag stay stable while stalled.
  - On release, all 5 results emerge in order with tags intact and none lost or duplicated.
- Reset asserted mid-stream with 2 operations in flight: out_valid drops immediately; no stale result appears after deassert.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared types, flag indices and helpers for the pipelined FP multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  // Bit positions inside the {invalid, overflow, underflow, inexact} flag vector
  localparam int c_flag_invalid   = 3;
  localparam int c_flag_overflow  = 2;
  localparam int c_flag_underflow = 1;
  localparam int c_flag_inexact   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic man_zero);
    if (exp_zero) return FP_ZERO;
    if (exp_ones) return man_zero ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_round
// Brief    : Combinational normalise, guard/sticky extraction and
//            round-to-nearest-even for the raw mantissa product.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 15
) (
  input  logic [2*MAN_W+1:0] prod,
  input  logic [EXP_W+1:0]   exp_in,
  output logic [MAN_W-1:0]   man,
  output logic [EXP_W+1:0]   exp_out,
  output logic               inexact
);

  localparam int c_pw = 2 * MAN_W + 2;

  logic              w_msb;
  logic [c_pw-2:0]   w_norm;
  logic [MAN_W-1:0]  w_frac;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [MAN_W:0]    w_sum;

  // Product is in [1,4); align so the hidden one sits just above w_norm
  assign w_msb    = prod[c_pw-1];
  assign w_norm   = w_msb ? prod[c_pw-2:0] : {prod[c_pw-3:0], 1'b0};
  assign w_frac   = w_norm[c_pw-2 -: MAN_W];
  assign w_guard  = w_norm[MAN_W];
  assign w_sticky = |w_norm[MAN_W-1:0];
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);
  assign w_sum    = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};

  // A carry out of the rounded fraction leaves it all-zero, i.e. 2.0 = 1.0 x 2^1
  assign man      = w_sum[MAN_W-1:0];
  assign exp_out  = exp_in + {{(EXP_W+1){1'b0}}, w_msb} + {{(EXP_W+1){1'b0}}, w_sum[MAN_W]};
  assign inexact  = w_guard | w_sticky;

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Brief    : Three-stage pipelined FP multiplier, RNE, tagged, valid/ready.
//            Optional out_flags port enabled by macro FP_MUL_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 15,
  parameter int TAG_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [TAG_W-1:0]       out_tag
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]             out_flags
`endif
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_pw = 2 * MAN_W + 2;
  localparam logic [63:0]      c_nan_full = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [c_w-1:0]   c_nan      = c_nan_full[c_w-1:0];
  localparam logic [EXP_W+1:0] c_bias     = (EXP_W+2)'(fp_bias(EXP_W));
  localparam logic [EXP_W+1:0] c_exp_max  = (EXP_W+2)'((1 << EXP_W) - 1);

  // ---------------------------------------------------------------- handshake
  logic r_v1, r_v2, r_v3;
  logic w_advance;

  assign w_advance = !r_v3 | out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_v3;

  // ---------------------------------------------------------- stage 1 inputs
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  fp_class_e        w_cls_a, w_cls_b, w_cls1;
  logic [EXP_W+1:0] w_exp1;
  logic [c_pw-1:0]  w_prod1;

  assign w_ea    = in_a[c_w-2 -: EXP_W];
  assign w_eb    = in_b[c_w-2 -: EXP_W];
  assign w_ma    = in_a[MAN_W-1:0];
  assign w_mb    = in_b[MAN_W-1:0];
  assign w_cls_a = fp_classify(w_ea == '0, &w_ea, w_ma == '0);
  assign w_cls_b = fp_classify(w_eb == '0, &w_eb, w_mb == '0);
  assign w_exp1  = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;
  assign w_prod1 = {{(MAN_W+1){1'b0}}, 1'b1, w_ma} * {{(MAN_W+1){1'b0}}, 1'b1, w_mb};

  always_comb begin
    w_cls1 = FP_NORM;
    if (w_cls_a == FP_NAN || w_cls_b == FP_NAN ||
        (w_cls_a == FP_INF && w_cls_b == FP_ZERO) ||
        (w_cls_a == FP_ZERO && w_cls_b == FP_INF))
      w_cls1 = FP_NAN;
    else if (w_cls_a == FP_INF || w_cls_b == FP_INF)
      w_cls1 = FP_INF;
    else if (w_cls_a == FP_ZERO || w_cls_b == FP_ZERO)
      w_cls1 = FP_ZERO;
  end

  // ------------------------------------------------------- stage 1 registers
  logic             r1_sign;
  fp_class_e        r1_cls;
  logic [EXP_W+1:0] r1_exp;
  logic [c_pw-1:0]  r1_prod;
  logic [TAG_W-1:0] r1_tag;

  // ---------------------------------------------------------------- rounding
  logic [MAN_W-1:0] w_rnd_man;
  logic [EXP_W+1:0] w_rnd_exp;
  logic             w_rnd_inexact;

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .prod    (r1_prod),
    .exp_in  (r1_exp),
    .man     (w_rnd_man),
    .exp_out (w_rnd_exp),
    .inexact (w_rnd_inexact)
  );

  // ------------------------------------------------------- stage 2 registers
  logic             r2_sign;
  fp_class_e        r2_cls;
  logic [EXP_W+1:0] r2_exp;
  logic [MAN_W-1:0] r2_man;
  logic [TAG_W-1:0] r2_tag;
`ifdef FP_MUL_FLAGS_EN
  logic             r2_inexact;
  logic [3:0]       w_flags3;
`else
  logic             w_unused_inexact;
  assign w_unused_inexact = w_rnd_inexact;
`endif

  // ------------------------------------------------- stage 3 range and pack
  logic [c_w-1:0] w_res3;

  always_comb begin
    w_res3 = '0;
`ifdef FP_MUL_FLAGS_EN
    w_flags3 = '0;
`endif
    case (r2_cls)
      FP_NAN: begin
        w_res3 = c_nan;
`ifdef FP_MUL_FLAGS_EN
        w_flags3[c_flag_invalid] = 1'b1;
`endif
      end
      FP_INF:  w_res3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: w_res3 = {r2_sign, {(c_w-1){1'b0}}};
      default: begin
        // Exponent MSB is the sign bit of the biased sum
        if (r2_exp[EXP_W+1] || r2_exp == '0) begin
          w_res3 = {r2_sign, {(c_w-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
          w_flags3[c_flag_underflow] = 1'b1;
          w_flags3[c_flag_inexact]   = 1'b1;
`endif
        end else if (r2_exp >= c_exp_max) begin
          w_res3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
          w_flags3[c_flag_overflow] = 1'b1;
          w_flags3[c_flag_inexact]  = 1'b1;
`endif
        end else begin
          w_res3 = {r2_sign, r2_exp[EXP_W-1:0], r2_man};
`ifdef FP_MUL_FLAGS_EN
          w_flags3[c_flag_inexact] = r2_inexact;
`endif
        end
      end
    endcase
  end

  // ------------------------------------------------------- pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r1_sign  <= 1'b0;
      r1_cls   <= FP_ZERO;
      r1_exp   <= '0;
      r1_prod  <= '0;
      r1_tag   <= '0;
      r2_sign  <= 1'b0;
      r2_cls   <= FP_ZERO;
      r2_exp   <= '0;
      r2_man   <= '0;
      r2_tag   <= '0;
      out_data <= '0;
      out_tag  <= '0;
`ifdef FP_MUL_FLAGS_EN
      r2_inexact <= 1'b0;
      out_flags  <= '0;
`endif
    end else if (w_advance) begin
      r_v1     <= in_valid;
      r1_sign  <= in_a[c_w-1] ^ in_b[c_w-1];
      r1_cls   <= w_cls1;
      r1_exp   <= w_exp1;
      r1_prod  <= w_prod1;
      r1_tag   <= in_tag;
      r_v2     <= r_v1;
      r2_sign  <= r1_sign;
      r2_cls   <= r1_cls;
      r2_exp   <= w_rnd_exp;
      r2_man   <= w_rnd_man;
      r2_tag   <= r1_tag;
      r_v3     <= r_v2;
      out_data <= w_res3;
      out_tag  <= r2_tag;
`ifdef FP_MUL_FLAGS_EN
      r2_inexact <= w_rnd_inexact;
      out_flags  <= w_flags3;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_pipe
// Brief    : Directed scoreboard bench for fp_mul_pipe at default widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  localparam int c_w = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [c_w-1:0]  in_a, in_b;
  logic [1:0]      in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [c_w-1:0]  out_data;
  logic [1:0]      out_tag;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]      out_flags;
`endif

  typedef struct packed {
    logic [c_w-1:0] data;
    logic [1:0]     tag;
    logic [3:0]     flags;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(15), .TAG_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef FP_MUL_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pair, record its expected result, return one tick after acceptance
  task automatic send(input logic [c_w-1:0] a, input logic [c_w-1:0] b, input logic [1:0] t,
                      input logic [c_w-1:0] r, input logic [3:0] f);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    #1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    sb.push_back('{data: r, tag: t, flags: f});
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  // Consumer side: each handshake pops the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_output observed=%h expected=none", out_data);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data", {8'd0, out_data}, {8'd0, e.data});
        check("tag", {30'd0, out_tag}, {30'd0, e.tag});
`ifdef FP_MUL_FLAGS_EN
        check("flags", {28'd0, out_flags}, {28'd0, e.flags});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [c_w-1:0] d0;
    logic [1:0]     t0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_out_tag", {30'd0, out_tag}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: 1.5 x 1.5
    send(24'h3FC000, 24'h3FC000, 2'd1, 24'h401000, 4'b0000);
    check("lat_c1", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_c2", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_c3", {31'd0, out_valid}, 32'd1);
    check("lat_data", {8'd0, out_data}, 32'h00401000);
    wait_empty();

    // Rounding, overflow, invalid, underflow sequence back to back
    send(24'h3FC000, 24'h3F8001, 2'd2, 24'h3FC002, 4'b0001);
    send(24'h7F7FFF, 24'h400000, 2'd3, 24'h7F8000, 4'b0101);
    send(24'h7F8000, 24'h000000, 2'd0, 24'h7FC000, 4'b1000);
    send(24'h008000, 24'h3F0000, 2'd1, 24'h000000, 4'b0011);
    send(24'h808000, 24'h3F0000, 2'd2, 24'h800000, 4'b0011);
    send(24'hBFC000, 24'h3FC000, 2'd3, 24'hC01000, 4'b0000);
    send(24'h7FC123, 24'h3F8000, 2'd0, 24'h7FC000, 4'b1000);
    send(24'hFF8000, 24'h3F8000, 2'd1, 24'hFF8000, 4'b0000);
    wait_empty();

    // Backpressure: fill the pipe with out_ready low
    out_ready = 1'b0;
    send(24'h3FC000, 24'h3FC000, 2'd0, 24'h401000, 4'b0000);
    send(24'h3F8000, 24'h3F8000, 2'd1, 24'h3F8000, 4'b0000);
    send(24'hBFC000, 24'h3FC000, 2'd2, 24'hC01000, 4'b0000);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    d0       = out_data;
    t0       = out_tag;
    in_valid = 1'b1;
    in_a     = 24'h400000;
    in_b     = 24'h400000;
    in_tag   = 2'd3;
    sb.push_back('{data: 24'h408000, tag: 2'd3, flags: 4'b0000});
    repeat (6) begin
      step();
      check("bp_hold_data", {8'd0, out_data}, {8'd0, d0});
      check("bp_hold_tag", {30'd0, out_tag}, {30'd0, t0});
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    send(24'h3FC000, 24'h400000, 2'd0, 24'h404000, 4'b0000);
    wait_empty();

    // Reset with operations in flight
    out_ready = 1'b0;
    send(24'h3F8000, 24'h3F8000, 2'd1, 24'h3F8000, 4'b0000);
    send(24'h400000, 24'h400000, 2'd2, 24'h408000, 4'b0000);
    step();
    check("mid_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    step();
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (8) step();
    check("post_rst_quiet", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
